// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: filtered frame receiver, E0/F0 prefix
// decoder, held-key table and first-word-fall-through event FIFO.
module ps2_key_tracker #(
  parameter int FILTER_LEN = 8,
  parameter int NUM_KEYS = 4,
  parameter logic [NUM_KEYS*8-1:0] KEY_CODES =
    {8'h1d, 8'h1b, 8'h23, 8'h1c},
  parameter logic [NUM_KEYS-1:0] KEY_EXT = '0,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ps2c,
  input  logic                ps2d,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                event_valid,
  output logic [7:0]          event_code,
  output logic                event_ext,
  output logic                event_break,
  input  logic                event_ready,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, RX} state_t;

  logic [1:0]            c_sync;
  logic [1:0]            d_sync;
  logic [FILTER_LEN-1:0] filt;
  logic                  fclk;
  logic                  fall;

  state_t                state;
  logic [3:0]            cnt;
  logic [8:0]            shreg;
  logic [WW-1:0]         wd;
  logic [WW-1:0]         wd_next;
  logic                  byte_valid;
  logic [7:0]            byte_data;

  logic                  ext_f;
  logic                  brk_f;
  logic                  is_e0;
  logic                  is_f0;
  logic                  ev_valid;
  logic [7:0]            ev_code;
  logic                  ev_ext;
  logic                  ev_brk;

  logic [9:0]            mem [FIFO_DEPTH];
  logic [AW-1:0]         wp;
  logic [AW-1:0]         rp;
  logic [AW:0]           count;
  logic                  full;
  logic                  pop;
  logic                  push;

  // fclk only moves once the filter window is unanimous
  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
      filt   <= '1;
      fclk   <= 1'b1;
      fall   <= 1'b0;
    end else begin
      c_sync <= {c_sync[0], ps2c};
      d_sync <= {d_sync[0], ps2d};
      filt   <= {filt[FILTER_LEN-2:0], c_sync[1]};
      fall   <= 1'b0;
      if (&filt) begin
        fclk <= 1'b1;
      end else if (~|filt) begin
        fclk <= 1'b0;
        fall <= fclk;
      end
    end
  end

  assign wd_next = wd + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      wd         <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          wd <= '0;
          if (fall) begin
            if (d_sync[1]) begin
              frame_err <= 1'b1;
            end else begin
              cnt   <= 4'd10;
              state <= RX;
            end
          end
        end
        RX: begin
          if (fall) begin
            wd    <= '0;
            shreg <= {d_sync[1], shreg[8:1]};
            cnt   <= cnt - 4'd1;
            // shreg holds d0..d7 then parity; this fall is the stop bit
            if (cnt == 4'd1) begin
              state <= IDLE;
              if (!d_sync[1]) begin
                frame_err <= 1'b1;
              end else if (!(^shreg)) begin
                parity_err <= 1'b1;
              end else begin
                byte_valid <= 1'b1;
                byte_data  <= shreg[7:0];
              end
            end
          end else if (wd_next == TO_LAST) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            wd <= wd_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign is_e0 = byte_data == 8'he0;
  assign is_f0 = byte_data == 8'hf0;

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_f    <= 1'b0;
      brk_f    <= 1'b0;
      ev_valid <= 1'b0;
      ev_code  <= '0;
      ev_ext   <= 1'b0;
      ev_brk   <= 1'b0;
    end else begin
      ev_valid <= 1'b0;
      unique case (1'b1)
        parity_err | frame_err: begin
          ext_f <= 1'b0;
          brk_f <= 1'b0;
        end
        byte_valid & is_e0: ext_f <= 1'b1;
        byte_valid & is_f0: brk_f <= 1'b1;
        byte_valid & ~is_e0 & ~is_f0: begin
          ev_valid <= 1'b1;
          ev_code  <= byte_data;
          ev_ext   <= ext_f;
          ev_brk   <= brk_f;
          ext_f    <= 1'b0;
          brk_f    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_held <= '0;
    end else if (ev_valid) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (ev_code == KEY_CODES[8*i +: 8] &&
            ev_ext == KEY_EXT[i]) begin
          key_held[i] <= ~ev_brk;
        end
      end
    end
  end

  assign full        = count == (AW+1)'(FIFO_DEPTH);
  assign event_valid = count != '0;
  assign pop         = event_valid & event_ready;
  assign push        = ev_valid & (~full | pop);

  assign {event_code, event_ext, event_break} =
    event_valid ? mem[rp] : 10'd0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= {ev_code, ev_ext, ev_brk};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= ev_valid & full & ~pop;
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: bit-banged PS/2 frames, event
// scoreboard queue, key/pulse checks per scenario.
module tb_ps2_key_tracker;

  localparam int L    = 8;
  localparam int T    = 100;
  localparam int FD   = 4;
  localparam int HALF = 20;

  logic       clk;
  logic       reset;
  logic       ps2c;
  logic       ps2d;
  logic [4:0] key_held;
  logic       event_valid;
  logic [7:0] event_code;
  logic       event_ext;
  logic       event_break;
  logic       event_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  ps2_key_tracker #(
    .FILTER_LEN(L),
    .NUM_KEYS(5),
    .KEY_CODES({8'h6b, 8'h1d, 8'h1b, 8'h23, 8'h1c}),
    .KEY_EXT(5'b10000),
    .TIMEOUT_CYCLES(T),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ps2c(ps2c),
    .ps2d(ps2d),
    .key_held(key_held),
    .event_valid(event_valid),
    .event_code(event_code),
    .event_ext(event_ext),
    .event_break(event_break),
    .event_ready(event_ready),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_perr = 0;
  int cnt_ferr = 0;
  int cnt_ovf  = 0;

  logic [9:0] exp_q [$];
  bit m_ext = 1'b0;
  bit m_brk = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (parity_err) cnt_perr++;
      if (frame_err)  cnt_ferr++;
      if (overflow)   cnt_ovf++;
    end
  end

  task automatic model_byte(input logic [7:0] b, input bit bad);
    if (bad) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'he0) begin
      m_ext = 1'b1;
    end else if (b == 8'hf0) begin
      m_brk = 1'b1;
    end else begin
      if (exp_q.size() < FD) exp_q.push_back({b, m_ext, m_brk});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_bit(input logic v);
    ps2d = v;
    repeat (HALF) @(posedge clk);
    #1 ps2c = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 ps2c = 1'b1;
  endtask

  // pop_at_push: raise event_ready only in the cycle the event is written
  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit bad_stop, input bit pop_at_push);
    logic [10:0] bits;
    logic [9:0] got;
    logic [9:0] e;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(bits[i]);
    ps2d = bits[10];
    repeat (HALF) @(posedge clk);
    #1 ps2c = 1'b0;
    if (pop_at_push) begin
      repeat (L + 5) @(posedge clk);
      #1 event_ready = 1'b1;
      @(negedge clk);
      got = {event_code, event_ext, event_break};
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3ff;
      n_tests++;
      if (!event_valid || got !== e) begin
        n_fail++;
        $display("FAIL pop_at_push valid=%b got=%h exp=%h",
                 event_valid, got, e);
      end
      @(posedge clk);
      #1 event_ready = 1'b0;
      repeat (HALF - L - 6) @(posedge clk);
    end else begin
      repeat (HALF) @(posedge clk);
    end
    #1 ps2c = 1'b1;
    ps2d = 1'b1;
    repeat (2 * HALF) @(posedge clk);
    model_byte(b, bad_par | bad_stop);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input string tag);
    logic [9:0] got;
    logic [9:0] e;
    int guard;
    guard = 0;
    @(posedge clk);
    #1 event_ready = 1'b1;
    @(negedge clk);
    while (event_valid && guard < 20) begin
      got = {event_code, event_ext, event_break};
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3ff;
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s event code/ext/brk got=%h/%b/%b exp=%h/%b/%b",
                 tag, got[9:2], got[1], got[0], e[9:2], e[1], e[0]);
      end
      guard++;
      @(negedge clk);
    end
    event_ready = 1'b0;
    n_tests++;
    if (exp_q.size() != 0 || event_valid) begin
      n_fail++;
      $display("FAIL %s leftover missing=%0d valid=%b exp_valid=0",
               tag, exp_q.size(), event_valid);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({key_held, event_valid, event_code, event_ext, event_break,
         parity_err, frame_err, overflow} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_hold outputs key=%b valid=%b code=%h exp=0",
               key_held, event_valid, event_code);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++;
    if ({key_held, event_valid, event_code, event_ext, event_break,
         parity_err, frame_err, overflow} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_release outputs key=%b valid=%b exp=0",
               key_held, event_valid);
    end
  endtask

  task automatic test_make_break;
    send(8'h1d);
    n_tests++;
    if (key_held !== 5'b01000) begin
      n_fail++;
      $display("FAIL mb_make key_held=%b exp=01000", key_held);
    end
    send(8'hf0);
    n_tests++;
    if (key_held !== 5'b01000) begin
      n_fail++;
      $display("FAIL mb_prefix key_held=%b exp=01000", key_held);
    end
    send(8'h1d);
    n_tests++;
    if (key_held !== 5'b00000) begin
      n_fail++;
      $display("FAIL mb_break key_held=%b exp=00000", key_held);
    end
    drain("mb_fifo");
  endtask

  task automatic test_simultaneous;
    send(8'h1d);
    send(8'h1c);
    n_tests++;
    if (key_held !== 5'b01001) begin
      n_fail++;
      $display("FAIL sim_both key_held=%b exp=01001", key_held);
    end
    send(8'h1d);
    n_tests++;
    if (key_held !== 5'b01001) begin
      n_fail++;
      $display("FAIL sim_repeat key_held=%b exp=01001", key_held);
    end
    send(8'hf0);
    send(8'h1d);
    n_tests++;
    if (key_held !== 5'b00001) begin
      n_fail++;
      $display("FAIL sim_release key_held=%b exp=00001", key_held);
    end
    drain("sim_fifo");
    send(8'hf0);
    send(8'h1c);
    drain("sim_fifo2");
  endtask

  task automatic test_extended;
    send(8'h6b);
    n_tests++;
    if (key_held !== 5'b00000) begin
      n_fail++;
      $display("FAIL ext_plain key_held=%b exp=00000", key_held);
    end
    send(8'he0);
    send(8'h6b);
    n_tests++;
    if (key_held !== 5'b10000) begin
      n_fail++;
      $display("FAIL ext_make key_held=%b exp=10000", key_held);
    end
    send(8'he0);
    send(8'hf0);
    send(8'h6b);
    n_tests++;
    if (key_held !== 5'b00000) begin
      n_fail++;
      $display("FAIL ext_break key_held=%b exp=00000", key_held);
    end
    drain("ext_fifo");
  endtask

  task automatic test_parity;
    int p0;
    p0 = cnt_perr;
    send_frame(8'h1d, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (cnt_perr - p0 !== 1 || key_held !== 5'b00000) begin
      n_fail++;
      $display("FAIL par_bad pulses=%0d key=%b exp=1/00000",
               cnt_perr - p0, key_held);
    end
    drain("par_none");
    send(8'hf0);
    send_frame(8'h1c, 1'b1, 1'b0, 1'b0);
    send(8'h1c);
    n_tests++;
    if (cnt_perr - p0 !== 2 || key_held !== 5'b00001) begin
      n_fail++;
      $display("FAIL par_clr_brk pulses=%0d key=%b exp=2/00001",
               cnt_perr - p0, key_held);
    end
    drain("par_fifo");
    send(8'hf0);
    send(8'h1c);
    drain("par_rel");
  endtask

  task automatic test_frame_errors;
    int f0;
    f0 = cnt_ferr;
    send_bit(1'b1);
    repeat (2 * HALF) @(posedge clk);
    model_byte(8'h00, 1'b1);
    n_tests++;
    if (cnt_ferr - f0 !== 1) begin
      n_fail++;
      $display("FAIL fe_start pulses=%0d exp=1", cnt_ferr - f0);
    end
    send(8'he0);
    send_frame(8'h1d, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (cnt_ferr - f0 !== 2 || key_held !== 5'b00000) begin
      n_fail++;
      $display("FAIL fe_stop pulses=%0d key=%b exp=2/00000",
               cnt_ferr - f0, key_held);
    end
    send(8'h1d);
    n_tests++;
    if (key_held !== 5'b01000) begin
      n_fail++;
      $display("FAIL fe_after key_held=%b exp=01000", key_held);
    end
    send(8'hf0);
    send(8'h1d);
    drain("fe_fifo");
  endtask

  task automatic test_timeout;
    int f0;
    int mism;
    int first;
    logic [3:0] part;
    f0 = cnt_ferr;
    part = 4'b0100;
    send(8'he0);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(part[i]);
    ps2d = part[3];
    repeat (HALF) @(posedge clk);
    #1 ps2c = 1'b0;
    mism = 0;
    first = -1;
    for (int n = 0; n < L + T + 8; n++) begin
      @(posedge clk);
      if (n == HALF) #1 ps2c = 1'b1;
      @(negedge clk);
      if (frame_err && first < 0) first = n;
      if (frame_err !== (n == L + 2 + T)) mism++;
    end
    ps2d = 1'b1;
    model_byte(8'h00, 1'b1);
    n_tests++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL to_timing first_high=%0d bad_cycles=%0d exp=%0d/0",
               first, mism, L + 2 + T);
    end
    n_tests++;
    if (cnt_ferr - f0 !== 1) begin
      n_fail++;
      $display("FAIL to_pulses got=%0d exp=1", cnt_ferr - f0);
    end
    send(8'h1c);
    n_tests++;
    if (key_held !== 5'b00001) begin
      n_fail++;
      $display("FAIL to_recover key_held=%b exp=00001", key_held);
    end
    send(8'hf0);
    send(8'h1c);
    drain("to_fifo");
  endtask

  task automatic test_overflow;
    int o0;
    o0 = cnt_ovf;
    send(8'h15);
    send(8'h16);
    send(8'h1e);
    send(8'h26);
    n_tests++;
    if (cnt_ovf - o0 !== 0 || event_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_full pulses=%0d valid=%b exp=0/1",
               cnt_ovf - o0, event_valid);
    end
    send(8'h25);
    n_tests++;
    if (cnt_ovf - o0 !== 1) begin
      n_fail++;
      $display("FAIL ovf_drop pulses=%0d exp=1", cnt_ovf - o0);
    end
    send_frame(8'h2e, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (cnt_ovf - o0 !== 1) begin
      n_fail++;
      $display("FAIL ovf_pushpop pulses=%0d exp=1", cnt_ovf - o0);
    end
    drain("ovf_fifo");
  endtask

  task automatic test_reset_mid_frame;
    send(8'h1d);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({key_held, event_valid, event_code, event_ext, event_break,
         parity_err, frame_err, overflow} !== 19'd0) begin
      n_fail++;
      $display("FAIL rst_mid outputs key=%b valid=%b code=%h exp=0",
               key_held, event_valid, event_code);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    repeat (2 * HALF) @(posedge clk);
    send(8'h1c);
    n_tests++;
    if (key_held !== 5'b00001) begin
      n_fail++;
      $display("FAIL rst_recover key_held=%b exp=00001", key_held);
    end
    drain("rst_fifo");
  endtask

  initial begin
    reset = 1'b1;
    ps2c = 1'b1;
    ps2d = 1'b1;
    event_ready = 1'b0;
    test_reset();
    test_make_break();
    test_simultaneous();
    test_extended();
    test_parity();
    test_frame_errors();
    test_timeout();
    test_overflow();
    test_reset_mid_frame();
    n_tests++;
    if (cnt_perr !== 2 || cnt_ferr !== 3 || cnt_ovf !== 1) begin
      n_fail++;
      $display("FAIL pulse_totals perr/ferr/ovf=%0d/%0d/%0d exp=2/3/1",
               cnt_perr, cnt_ferr, cnt_ovf);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Parametrised PS/2 keyboard front end: debounces the PS/2 clock, receives 11-bit frames with start/parity/stop checking and a bit-timeout watchdog, decodes E0/F0 prefixes into make/break events, and tracks the held state of a configurable set of keys at once. It sits between the board PS/2 pins and the game control logic. Ship control reads `key_held` levels so simultaneous keys work, for example thrust plus turn. Other logic drains decoded events from a small FIFO.

## Interface
- `FILTER_LEN`, 8: ps2c debounce shift-register length, ≥2.
- `NUM_KEYS`, 4: number of tracked keys.
- `KEY_CODES`, {8'h1d,8'h1b,8'h23,8'h1c}: NUM_KEYS×8 packed; entry i is bits [8i+7:8i]; default i0=a, i1=d, i2=s, i3=w.
- `KEY_EXT`, 4'b0000: NUM_KEYS bits; 1 means entry i requires the E0 prefix.
- `TIMEOUT_CYCLES`, 50000: clk cycles allowed without a ps2c falling edge during a frame.
- `FIFO_DEPTH`, 4: event FIFO entries; power of 2, ≥2.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high. One clock; all state updates on posedge `clk`.
- `ps2c`, in, 1: PS/2 clock, asynchronous to `clk`.
- `ps2d`, in, 1: PS/2 data.
- `key_held`, out, NUM_KEYS: level; bit i = key i currently pressed.
- `event_valid`, out, 1: FIFO not empty.
- `event_code`, out, 8: head event scan code.
- `event_ext`, out, 1: head event had the E0 prefix.
- `event_break`, out, 1: head event is a release (F0 prefix).
- `event_ready`, in, 1: consumer pop.
- `parity_err`, out, 1: 1-cycle pulse on a bad odd-parity frame.
- `frame_err`, out, 1: 1-cycle pulse on a bad start bit, bad stop bit or timeout.
- `overflow`, out, 1: 1-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- **Sync and filter:**
  - ps2c and ps2d each pass a 2-flop synchroniser.
  - The filtered clock `fclk` sets when the FILTER_LEN-bit shift register is all 1s and clears when it is all 0s; otherwise it holds.
  - `fall` is asserted for one cycle when `fclk` goes 1→0.
  - Sampled ps2d is the synchronised value in the `fall` cycle.
- **Frame FSM, states IDLE and RX:**
  - IDLE: on `fall`, sample the start bit. If 0, load bit count 10 and enter RX. If 1, pulse `frame_err` and stay in IDLE.
  - RX: on each `fall`, shift ps2d into the data register LSB-first and decrement the count. When the count reaches 0 after the stop bit, check the frame and return to IDLE.
  - Check order: stop bit ≠1 → `frame_err`. Otherwise, XOR of the 8 data bits and the parity bit ≠1 → `parity_err`. Otherwise, raise the internal `byte_valid` for 1 cycle.
  - The watchdog counter clears on every `fall` and counts in RX. At TIMEOUT_CYCLES−1 it pulses `frame_err`, returns to IDLE and discards partial data.
- **Prefix decoder:**
  - Holds flags `ext` and `brk`.
  - Byte E0 sets `ext`; byte F0 sets `brk`, in any order.
  - Any other byte forms the event {code, ext, brk}, then clears both flags.
  - `parity_err` or `frame_err` clears both flags.
- **Key table:**
  - For every event, each i with code==KEY_CODES[i] and ext==KEY_EXT[i] sets key_held[i] to !brk.
  - Typematic repeat makes leave the state unchanged.
  - If duplicate table entries exist, all matching bits update.
- **FIFO:**
  - First-word-fall-through; head fields are valid while `event_valid` is high.
  - Pop happens when `event_valid & event_ready`.
  - Every event is pushed, tracked or not.
  - Push when full without a same-cycle pop: drop the new event, pulse `overflow`, leave contents unchanged.
  - Push and pop in the same cycle while full: both proceed, no drop.
  - `event_ready` while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits.
- **Reset:**
  - Filter register is all 1s and `fclk`=1, so there is no spurious edge.
  - Frame FSM is in IDLE; flags, watchdog and FIFO are cleared.
  - Outputs: `key_held`=0, `event_valid`=0, `event_code`=0, `event_ext`=0, `event_break`=0, all pulses 0.
  - Reset mid-frame abandons the frame with no error pulse. The keyboard's remaining bits are then seen as a new frame and may produce `frame_err`, which is acceptable.

## Timing
- ps2c edge to `fall`: 2 sync cycles plus FILTER_LEN cycles of stable level plus 1.
- Let S be the cycle `fall` is high for the stop bit:
  - `byte_valid`, `parity_err` and `frame_err` are high in cycle S+1.
  - Event formation, the `key_held` update and the FIFO write take effect at the end of S+2. `event_valid` from an empty FIFO is high in cycle S+3.
- Pop: the head advances the cycle after the pop handshake; `event_valid` drops the cycle after the last entry is popped.
- Watchdog `frame_err` is high exactly TIMEOUT_CYCLES cycles after the last `fall` in RX.

## Test plan
- **Make then break of `w`:** bytes 1D, F0, 1D. `key_held`=4'b1000 after the first byte, 0 after the third. FIFO pops {1D,0,0} then {1D,0,1}.
- **Simultaneous keys:** 1D, 1C, F0 1D. `key_held` goes 1000 → 1001 → 0001.
- **Extended key with KEY_EXT[0]=1 and KEY_CODES[0]=6B:**
  - E0 6B sets bit 0. A plain 6B does not set it.
  - E0 F0 6B clears bit 0. The event reads {6B, ext=1, break=1}.
- **Parity error:** frame 1D with its parity bit flipped gives `parity_err` for 1 cycle, no event and no `key_held` change. A following F0-then-bad-parity sequence also clears `brk`.
- **Timeout:** with TIMEOUT_CYCLES=100, send start plus 4 data bits then stall. `frame_err` is high exactly 100 cycles after the last edge. A later valid 1C is received correctly.
- **Overflow:** FIFO_DEPTH=4, `event_ready`=0, 5 make codes.
  - After the 4th, the FIFO is full; the 5th pulses `overflow` and is dropped.
  - Hold `event_ready`=1 while sending a 6th code on a full FIFO: no `overflow`, and the count stays at 4.
  - Reset mid-frame: all outputs return to 0.
